reduce_gate_acc: RTL

REDUCE_GATE_ACC -- requirements
Module: reduce_gate_acc

---
 rtl/reduce_gate_pkg.sv | 24 ++
 rtl/reduce_gate_core.sv | 12 +
 rtl/reduce_gate_acc.sv | 59 +++++
 3 files changed

// File: rtl/reduce_gate_pkg.sv
// reduce_gate_pkg: op encodings, FSM states and base-op helpers for reduce_gate_acc
package reduce_gate_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
  typedef enum logic [1:0] {B_AND, B_OR, B_XOR} base_t;
  function automatic base_t base_of(input logic [2:0] op);
    return (op == OP_OR || op == OP_NOR) ? B_OR :
           (op == OP_XOR || op == OP_XNOR) ? B_XOR : B_AND;
  endfunction
  function automatic logic inv_of(input logic [2:0] op);
    return op == OP_NAND || op == OP_NOR || op == OP_XNOR;
  endfunction
  function automatic logic is_rsvd(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
  function automatic logic fold(input logic a, input logic b, input base_t base);
    return base == B_AND ? a & b : base == B_OR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/reduce_gate_core.sv
// reduce_gate_core: reduces one beat of gate inputs with the selected base op
module reduce_gate_core
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  input  base_t            base,
  output logic             r
);
  always_comb r = base == B_AND ? &data : base == B_OR ? |data : ^data;
endmodule

// File: rtl/reduce_gate_acc.sv
// reduce_gate_acc: accumulates per-beat gate reductions over a frame and offers one result
module reduce_gate_acc
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_op,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               y,
  output logic [COUNT_W-1:0] y_count,
  output logic               y_err,
  output logic               y_valid,
  input  logic               y_ready
);
  state_t     state;
  logic [2:0] op_q;
  logic       acc;
  logic       take;
  logic       first;
  logic       r;
  logic [2:0] op_eff;
  base_t      base;
  assign in_ready = state != S_HOLD;
  assign y_valid  = state == S_HOLD;
  assign take     = in_valid && in_ready;
  assign first    = state == S_IDLE;
  assign op_eff   = first ? in_op : op_q;
  assign base     = base_of(op_eff);
  // inversion is applied once here, never folded into the per-beat accumulator
  assign y        = y_err ? 1'b0 : acc ^ inv_of(op_q);
  reduce_gate_core #(.WIDTH(WIDTH)) u_core (
    .data(in_data),
    .base(base),
    .r   (r)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_AND;
      acc     <= 1'b0;
      y_count <= '0;
      y_err   <= 1'b0;
    end else if (take) begin
      op_q    <= op_eff;
      acc     <= first ? r : fold(acc, r, base);
      y_count <= first ? COUNT_W'(1) : (&y_count ? y_count : y_count + COUNT_W'(1));
      y_err   <= first ? is_rsvd(in_op) : y_err;
      state   <= in_last ? S_HOLD : S_ACCUM;
    end else if (state == S_HOLD && y_ready) begin
      state <= S_IDLE;
    end
  end
endmodule
